music_sequencer: RTL and testbench

- Control FSM driving the note datapath's ld_note, ld_play, note_counter, display_note and next_note_en inputs.
- Handles recording: user note entries are appended into the 16-entry note memory.
- Handles playback: stored notes are stepped through at a fixed note duration, feeding freq_select and the VGA note grid.
- Sits between the debounced board buttons/switch decoder and the datapath.

---
 rtl/music_pkg.sv | 27 ++
 rtl/note_timer.sv | 28 ++
 rtl/music_sequencer.sv | 135 +++++++++++++
 tb/tb_music_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared definitions for the music sequencer control path and its datapath/VGA neighbours.
package music_pkg;

   localparam int NUM_SLOTS          = 16;
   localparam int NOTE_TICKS_DEFAULT = 12500000;

   localparam logic [2:0] COLOR_RED    = 3'b100;
   localparam logic [2:0] COLOR_YELLOW = 3'b110;

   typedef logic [2:0] seq_state_t;

   localparam seq_state_t S_IDLE      = 3'd0;
   localparam seq_state_t S_REC_WAIT  = 3'd1;
   localparam seq_state_t S_REC_WRITE = 3'd2;
   localparam seq_state_t S_REC_GAP   = 3'd3;
   localparam seq_state_t S_PLAY_STEP = 3'd4;
   localparam seq_state_t S_PLAY_HOLD = 3'd5;

   function automatic logic is_rec_state(input seq_state_t s);
      return (s == S_REC_WAIT) || (s == S_REC_WRITE) || (s == S_REC_GAP);
   endfunction

   function automatic logic is_play_state(input seq_state_t s);
      return (s == S_PLAY_STEP) || (s == S_PLAY_HOLD);
   endfunction

endpackage

// File: rtl/note_timer.sv
// Note duration counter: holds 0 while clr_i is high, counts up otherwise.
// tc_o flags the terminal count NOTE_TICKS-2, one cycle before the next note boundary.
module note_timer #(
   parameter int TICK_W     = 32,
   parameter int NOTE_TICKS = 12500000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   output logic tc_o
);

   localparam logic [TICK_W-1:0] TERM = TICK_W'(NOTE_TICKS - 2);

   logic [TICK_W-1:0] tick_q, tick_d;

   always_comb begin
      tick_d = clr_i ? '0 : tick_q + TICK_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset) tick_q <= '0;
      else        tick_q <= tick_d;
   end

   assign tc_o = (tick_q == TERM);

endmodule

// File: rtl/music_sequencer.sv
// Record/playback control FSM for the note datapath; all outputs registered from next state.
// Build option MUSIC_SEQ_LOOP_EN: playback wraps to the first note until stopped.
module music_sequencer
   import music_pkg::*;
#(
   parameter int NOTE_TICKS = NOTE_TICKS_DEFAULT,
   parameter int TICK_W     = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rec_btn,
   input  logic       play_btn,
   input  logic       stop_btn,
   input  logic       note_valid,
   output logic       ld_note,
   output logic       ld_play,
   output logic [3:0] note_counter,
   output logic       display_note,
   output logic       next_note_en,
   output logic [4:0] note_count,
   output logic       recording,
   output logic       playing,
   output logic       full
);

   seq_state_t state_q, state_d;
   logic [4:0] note_count_q, note_count_d;
   logic [3:0] note_counter_q, note_counter_d;
   logic       ld_note_q, ld_play_q, display_note_q, next_note_en_q;
   logic       recording_q, playing_q, full_q;
   logic       tc;
   logic       full_now;
   logic       last_note;

   note_timer #(.TICK_W(TICK_W), .NOTE_TICKS(NOTE_TICKS)) u_timer (
      .clk   (clk),
      .reset (reset),
      .clr_i (state_q != S_PLAY_HOLD),
      .tc_o  (tc)
   );

   assign full_now  = (note_count_q == 5'(NUM_SLOTS));
   assign last_note = ({1'b0, note_counter_q} == (note_count_q - 5'd1));

   always_comb begin
      state_d        = state_q;
      note_count_d   = note_count_q;
      note_counter_d = note_counter_q;
      case (state_q)
         S_IDLE: begin
            if (stop_btn) begin
               state_d = S_IDLE;
            end else if (rec_btn) begin
               state_d = S_REC_WAIT;
            end else if (play_btn && (note_count_q != 5'd0)) begin
               state_d        = S_PLAY_STEP;
               note_counter_d = 4'd0;
            end
         end
         S_REC_WAIT: begin
            if (stop_btn) begin
               state_d = S_IDLE;
            end else if (note_valid && !full_now) begin
               state_d      = S_REC_WRITE;
               note_count_d = note_count_q + 5'd1;
            end
         end
         S_REC_WRITE: state_d = S_REC_GAP;
         // The gap cycle guarantees the datapath write enable drops between entries.
         S_REC_GAP:   state_d = full_now ? S_IDLE : S_REC_WAIT;
         S_PLAY_STEP: begin
            if (stop_btn) begin
               state_d        = S_IDLE;
               note_counter_d = 4'd0;
            end else begin
               state_d = S_PLAY_HOLD;
            end
         end
         S_PLAY_HOLD: begin
            if (stop_btn) begin
               state_d        = S_IDLE;
               note_counter_d = 4'd0;
            end else if (tc) begin
               note_counter_d = last_note ? 4'd0 : note_counter_q + 4'd1;
`ifdef MUSIC_SEQ_LOOP_EN
               state_d        = S_PLAY_STEP;
`else
               state_d        = last_note ? S_IDLE : S_PLAY_STEP;
`endif
            end
         end
         default: begin
            state_d        = S_IDLE;
            note_counter_d = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= S_IDLE;
         note_count_q   <= 5'd0;
         note_counter_q <= 4'd0;
         ld_note_q      <= 1'b0;
         ld_play_q      <= 1'b0;
         display_note_q <= 1'b0;
         next_note_en_q <= 1'b0;
         recording_q    <= 1'b0;
         playing_q      <= 1'b0;
         full_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         note_count_q   <= note_count_d;
         note_counter_q <= note_counter_d;
         ld_note_q      <= (state_d == S_REC_WRITE);
         ld_play_q      <= is_play_state(state_d);
         display_note_q <= (state_d == S_REC_WRITE) || (state_d == S_PLAY_STEP);
         next_note_en_q <= (state_d == S_PLAY_STEP);
         recording_q    <= is_rec_state(state_d);
         playing_q      <= is_play_state(state_d);
         full_q         <= (note_count_d == 5'(NUM_SLOTS));
      end
   end

   assign ld_note      = ld_note_q;
   assign ld_play      = ld_play_q;
   assign note_counter = note_counter_q;
   assign display_note = display_note_q;
   assign next_note_en = next_note_en_q;
   assign note_count   = note_count_q;
   assign recording    = recording_q;
   assign playing      = playing_q;
   assign full         = full_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Self-checking bench for music_sequencer with a short note duration.
module tb_music_sequencer;

   localparam int NT = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rec_btn = 1'b0, play_btn = 1'b0, stop_btn = 1'b0, note_valid = 1'b0;
   logic       ld_note, ld_play, display_note, next_note_en, recording, playing, full;
   logic [3:0] note_counter;
   logic [4:0] note_count;

   int n_tests = 0;
   int n_fail  = 0;
   int model_count = 0;
   int ld_hi = 0, ld_rise = 0;
   logic ld_prev = 1'b0;

   always #5 clk = ~clk;

   music_sequencer #(.NOTE_TICKS(NT), .TICK_W(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .rec_btn      (rec_btn),
      .play_btn     (play_btn),
      .stop_btn     (stop_btn),
      .note_valid   (note_valid),
      .ld_note      (ld_note),
      .ld_play      (ld_play),
      .note_counter (note_counter),
      .display_note (display_note),
      .next_note_en (next_note_en),
      .note_count   (note_count),
      .recording    (recording),
      .playing      (playing),
      .full         (full)
   );

   always @(negedge clk) begin
      if (ld_note) ld_hi++;
      if (ld_note && !ld_prev) ld_rise++;
      ld_prev = ld_note;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] outs();
      return {16'd0, ld_note, ld_play, note_counter, display_note, next_note_en,
              note_count, recording, playing, full};
   endfunction

   function automatic logic [31:0] idle_outs(input int cnt);
      return {16'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 5'(cnt), 1'b0, 1'b0, (cnt == 16)};
   endfunction

   task automatic play_song(input int n, input string tag);
      int total;
      total = n * NT;
      for (int c = 0; c <= total; c++) begin
         int exp_idx;
         logic exp_play, exp_strike;
`ifdef MUSIC_SEQ_LOOP_EN
         exp_play   = 1'b1;
         exp_idx    = (c / NT) % n;
         exp_strike = (c % NT) == 0;
`else
         exp_play   = c < total;
         exp_idx    = exp_play ? c / NT : 0;
         exp_strike = exp_play && ((c % NT) == 0);
`endif
         check_val({tag, "_idx"},     32'(note_counter), 32'(exp_idx));
         check_val({tag, "_next_en"}, 32'(next_note_en), 32'(exp_strike));
         check_val({tag, "_display"}, 32'(display_note), 32'(exp_strike));
         check_val({tag, "_ld_play"}, 32'(ld_play),      32'(exp_play));
         check_val({tag, "_playing"}, 32'(playing),      32'(exp_play));
         step();
      end
   endtask

   initial begin
      int h0, r0, gap;

      // Reset state
      repeat (3) step();
      check_val("reset_outs", outs(), 32'd0);
      reset = 1'b1;
      step();

      // Play with nothing stored is ignored
      play_btn = 1'b1; step(); play_btn = 1'b0;
      repeat (5) begin
         check_val("empty_ld_play", 32'(ld_play), 32'd0);
         check_val("empty_playing", 32'(playing), 32'd0);
         step();
      end
      check_val("empty_count", 32'(note_count), 32'd0);

      // Record three notes spaced 5 cycles
      rec_btn = 1'b1; step(); rec_btn = 1'b0;
      check_val("rec_enter", 32'(recording), 32'd1);
      h0 = ld_hi; r0 = ld_rise;
      for (int i = 0; i < 3; i++) begin
         note_valid = 1'b1; step(); note_valid = 1'b0;
         check_val("rec_ld_note", 32'(ld_note), 32'd1);
         check_val("rec_display", 32'(display_note), 32'd1);
         repeat (4) step();
      end
      model_count = 3;
      check_val("rec3_ld_cycles", 32'(ld_hi - h0), 32'd3);
      check_val("rec3_ld_pulses", 32'(ld_rise - r0), 32'd3);
      check_val("rec3_count", 32'(note_count), 32'(model_count));
      check_val("rec3_recording", 32'(recording), 32'd1);
      stop_btn = 1'b1; step(); stop_btn = 1'b0;
      check_val("rec3_stop", outs(), idle_outs(model_count));

      // Play three notes
      play_btn = 1'b1; step(); play_btn = 1'b0;
      play_song(model_count, "play3");
      stop_btn = 1'b1; step(); stop_btn = 1'b0;
      check_val("play3_end", outs(), idle_outs(model_count));

      // Back-to-back note_valid: only the first is written
      rec_btn = 1'b1; step(); rec_btn = 1'b0;
      h0 = ld_hi;
      note_valid = 1'b1; step();
      check_val("b2b_first", 32'(ld_note), 32'd1);
      step(); note_valid = 1'b0;
      check_val("b2b_second", 32'(ld_note), 32'd0);
      step();
      check_val("b2b_third", 32'(ld_note), 32'd0);
      step();
      model_count++;
      check_val("b2b_ld_cycles", 32'(ld_hi - h0), 32'd1);
      check_val("b2b_count", 32'(note_count), 32'(model_count));
      stop_btn = 1'b1; step(); stop_btn = 1'b0;

      // rec beats play; fill memory with random spacing
      rec_btn = 1'b1; play_btn = 1'b1; step(); rec_btn = 1'b0; play_btn = 1'b0;
      check_val("prio_recording", 32'(recording), 32'd1);
      check_val("prio_playing", 32'(playing), 32'd0);
      h0 = ld_hi;
      while (model_count < 16) begin
         gap = $urandom_range(3, 6);
         note_valid = 1'b1;
         rec_btn = 1'($urandom_range(0, 1));
         step();
         note_valid = 1'b0; rec_btn = 1'b0;
         check_val("fill_ld_note", 32'(ld_note), 32'd1);
         model_count++;
         repeat (gap - 1) step();
      end
      check_val("fill_ld_cycles", 32'(ld_hi - h0), 32'd12);
      check_val("fill_auto_idle", outs(), idle_outs(16));

      // Writes refused once full
      rec_btn = 1'b1; step(); rec_btn = 1'b0;
      check_val("full_rec", 32'(recording), 32'd1);
      h0 = ld_hi;
      repeat (3) begin
         note_valid = 1'b1; step(); note_valid = 1'b0;
         repeat (3) step();
      end
      check_val("full_no_write", 32'(ld_hi - h0), 32'd0);
      check_val("full_count", 32'(note_count), 32'd16);
      stop_btn = 1'b1; step(); stop_btn = 1'b0;
      check_val("full_stop", outs(), idle_outs(16));

      // Sixteen-note playback, then stop+play together mid-song
      play_btn = 1'b1; step(); play_btn = 1'b0;
      play_song(16, "play16");
`ifndef MUSIC_SEQ_LOOP_EN
      play_btn = 1'b1; step(); play_btn = 1'b0;
`endif
      repeat ($urandom_range(2, 30)) step();
      stop_btn = 1'b1; play_btn = 1'b1; step(); stop_btn = 1'b0; play_btn = 1'b0;
      check_val("stop_play_prio", outs(), idle_outs(16));

      // Reset mid-hold
      play_btn = 1'b1; step(); play_btn = 1'b0;
      repeat ($urandom_range(1, 6)) step();
      check_val("hold_playing", 32'(playing), 32'd1);
      reset = 1'b0; step();
      model_count = 0;
      check_val("mid_reset", outs(), idle_outs(0));
      reset = 1'b1; step();
      check_val("post_reset", outs(), idle_outs(0));

      play_btn = 1'b1; step(); play_btn = 1'b0;
      repeat (3) begin
         check_val("post_reset_play", 32'(ld_play), 32'd0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
